// File: rtl/mem_responder_pkg.sv
// mem_responder_pkg: types and helpers shared by the memory responder.
//   state_t   : responder FSM states
//   WAIT_W    : wait-state counter width
//   parity_f  : even-parity bit of a zero-extended word
package mem_responder_pkg;

  localparam int WAIT_W    = 4;
  localparam int PAR_MAX_W = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  // Returns the bit that makes the stored word plus parity an even count of ones.
  function automatic logic parity_f(input logic [PAR_MAX_W-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/mem_responder_array.sv
// mem_responder_array: DEPTH x WORD_W storage for the memory responder.
// Ports:
//   clock   : system clock
//   reset   : synchronous active-low; clears every word to zero
//   wr_en   : write strobe, writes wr_word at wr_idx on the rising edge
//   wr_idx  : write word index
//   wr_word : write word (data, plus parity bit when enabled in the top)
//   rd_idx  : read word index
//   rd_word : combinational read of word rd_idx
module mem_responder_array
  import mem_responder_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int WORD_W = 8,
  parameter int IDX_W  = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [WORD_W-1:0] wr_word,
  input  logic [IDX_W-1:0]  rd_idx,
  output logic [WORD_W-1:0] rd_word
);

  logic [WORD_W-1:0] mem [DEPTH];

  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (wr_en) begin
      mem[wr_idx] <= wr_word;
    end
  end

  assign rd_word = mem[rd_idx];

endmodule

// File: rtl/mem_responder.sv
// mem_responder: handshaked memory with fixed wait states for the fetch/operand bus.
// Build option: MEM_RESPONDER_PARITY_EN adds a stored even-parity bit per word,
// checked on reads (mismatch -> ack with err and the stored word on rdata).
// Ports:
//   clock : system clock
//   reset : synchronous active-low
//   req   : request strobe, sampled in IDLE only
//   we    : 1 = write, 0 = read (sampled with req)
//   addr  : word address (sampled with req)
//   wdata : write data (sampled with req)
//   ack   : one-cycle completion pulse
//   rdata : read data, valid with ack and held until the next ack
//   busy  : high from the cycle after acceptance through the ack cycle
//   err   : qualifies ack; out-of-range address or parity fault
//
// state | meaning
// IDLE  | waiting for req; the ack cycle of the previous access is spent here
// WAIT  | counting down wait states, bus inputs ignored
// RESP  | access performed; output registers load ack/err/rdata on exit
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 8,
  parameter int DEPTH       = 16,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              ack,
  output logic [DATA_W-1:0] rdata,
  output logic              busy,
  output logic              err
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
`ifdef MEM_RESPONDER_PARITY_EN
  localparam int WORD_W = DATA_W + 1;
`else
  localparam int WORD_W = DATA_W;
`endif

  state_t              state, state_nxt;
  logic [WAIT_W-1:0]   cnt;
  logic [ADDR_W-1:0]   addr_q;
  logic                we_q;
  logic [DATA_W-1:0]   wdata_q;
  logic                in_range;
  logic                mem_we;
  logic [WORD_W-1:0]   wr_word;
  logic [WORD_W-1:0]   rd_word;
  logic [DATA_W-1:0]   rd_data;
  logic                par_fault;
  logic                ack_d, busy_d, err_d;
  logic [DATA_W-1:0]   rdata_d;

  // One extra bit so DEPTH == 2**ADDR_W still compares correctly.
  assign in_range = ({1'b0, addr_q} < (ADDR_W + 1)'(DEPTH));

`ifdef MEM_RESPONDER_PARITY_EN
  assign wr_word   = {parity_f(PAR_MAX_W'(wdata_q)), wdata_q};
  assign rd_data   = rd_word[DATA_W-1:0];
  assign par_fault = rd_word[DATA_W] != parity_f(PAR_MAX_W'(rd_word[DATA_W-1:0]));
`else
  assign wr_word   = wdata_q;
  assign rd_data   = rd_word;
  assign par_fault = 1'b0;
`endif

  mem_responder_array #(
    .DEPTH  (DEPTH),
    .WORD_W (WORD_W),
    .IDX_W  (IDX_W)
  ) u_array (
    .clock   (clock),
    .reset   (reset),
    .wr_en   (mem_we),
    .wr_idx  (addr_q[IDX_W-1:0]),
    .wr_word (wr_word),
    .rd_idx  (addr_q[IDX_W-1:0]),
    .rd_word (rd_word)
  );

  always_ff @(posedge clock) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (req) state_nxt = (WAIT_CYCLES == 0) ? RESP : WAIT;
      WAIT: if (cnt == WAIT_W'(1)) state_nxt = RESP;
      RESP: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Request capture and wait-state down-counter.
  always_ff @(posedge clock) begin
    if (!reset) begin
      cnt     <= '0;
      addr_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
    end else begin
      case (state)
        IDLE: if (req) begin
          cnt     <= WAIT_W'(WAIT_CYCLES);
          addr_q  <= addr;
          we_q    <= we;
          wdata_q <= wdata;
        end
        WAIT: cnt <= cnt - 1'b1;
        default: ;
      endcase
    end
  end

  // Output next-values; they register on the edge leaving RESP, so ack lands
  // WAIT_CYCLES+1 edges after acceptance and the write commits on that same edge.
  always_comb begin
    ack_d   = (state == RESP);
    busy_d  = (state != IDLE);
    err_d   = 1'b0;
    rdata_d = rdata;
    mem_we  = 1'b0;
    if (state == RESP) begin
      if (!in_range) begin
        err_d = 1'b1;
        if (!we_q) rdata_d = '0;
      end else if (we_q) begin
        mem_we = 1'b1;
      end else begin
        rdata_d = rd_data;
        err_d   = par_fault;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      ack   <= 1'b0;
      busy  <= 1'b0;
      err   <= 1'b0;
      rdata <= '0;
    end else begin
      ack   <= ack_d;
      busy  <= busy_d;
      err   <= err_d;
      rdata <= rdata_d;
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: directed bench for mem_responder. u_dut uses WAIT_CYCLES=2,
// u_dut0 uses WAIT_CYCLES=0; both share reset and bus signals except req.
module tb_mem_responder;

  logic       clock = 1'b0;
  logic       reset;
  logic       req, req0, we;
  logic [7:0] addr, wdata;
  logic       ack, busy, err;
  logic [7:0] rdata;
  logic       ack0, busy0, err0;
  logic [7:0] rdata0;

  int n_tests = 0;
  int n_fail  = 0;
  logic [7:0] model [16];

  always #5 clock = ~clock;

  mem_responder #(.ADDR_W(8), .DATA_W(8), .DEPTH(16), .WAIT_CYCLES(2)) u_dut (
    .clock(clock), .reset(reset), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .ack(ack), .rdata(rdata), .busy(busy), .err(err)
  );

  mem_responder #(.ADDR_W(8), .DATA_W(8), .DEPTH(16), .WAIT_CYCLES(0)) u_dut0 (
    .clock(clock), .reset(reset), .req(req0), .we(we), .addr(addr), .wdata(wdata),
    .ack(ack0), .rdata(rdata0), .busy(busy0), .err(err0)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  // Single access on u_dut; lat = edges from acceptance to ack, 0 on timeout.
  task automatic txn(input logic w, input logic [7:0] a, input logic [7:0] d,
                     output logic [7:0] rd, output logic e, output int lat, output int bsy);
    req = 1'b1; we = w; addr = a; wdata = d;
    cyc();
    req = 1'b0;
    lat = 0; bsy = 0;
    for (int i = 1; i <= 20; i++) begin
      cyc();
      if (busy) bsy++;
      if (ack) begin
        lat = i;
        break;
      end
    end
    rd = rdata;
    e  = err;
  endtask

  initial begin
    logic [7:0] rd;
    logic       e;
    int         lat, bsy, t1, t2;
    logic       saw;

    reset = 1'b0; req = 1'b0; req0 = 1'b0; we = 1'b0; addr = '0; wdata = '0;
    for (int i = 0; i < 16; i++) model[i] = 8'h00;
    repeat (3) cyc();
    check("rst_ack", {31'd0, ack}, 0);
    check("rst_busy", {31'd0, busy}, 0);
    check("rst_err", {31'd0, err}, 0);
    check("rst_rdata", {24'd0, rdata}, 0);
    reset = 1'b1;
    cyc();

    // Reset in the first WAIT cycle abandons the write.
    req = 1'b1; we = 1'b1; addr = 8'd3; wdata = 8'h5A;
    cyc();
    req = 1'b0; reset = 1'b0;
    cyc();
    reset = 1'b1;
    check("rst_mid_busy", {31'd0, busy}, 0);
    saw = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cyc();
      if (ack) saw = 1'b1;
    end
    check("rst_mid_no_ack", {31'd0, saw}, 0);
    txn(1'b0, 8'd3, 8'h00, rd, e, lat, bsy);
    check("rst_mid_rd", {24'd0, rd}, 8'h00);
    check("rst_mid_err", {31'd0, e}, 0);

    // Write then read back, WAIT_CYCLES=2.
    txn(1'b1, 8'd5, 8'hA7, rd, e, lat, bsy);
    model[5] = 8'hA7;
    check("wr5_lat", lat, 3);
    check("wr5_err", {31'd0, e}, 0);
    txn(1'b0, 8'd5, 8'h00, rd, e, lat, bsy);
    check("rd5_lat", lat, 3);
    check("rd5_busy", bsy, 3);
    check("rd5_data", {24'd0, rd}, 8'hA7);
    check("rd5_err", {31'd0, e}, 0);
    cyc();
    check("ack_pulse", {31'd0, ack}, 0);
    check("busy_drop", {31'd0, busy}, 0);

    // Write leaves rdata unchanged.
    txn(1'b1, 8'd2, 8'h11, rd, e, lat, bsy);
    model[2] = 8'h11;
    check("wr2_rdata_hold", {24'd0, rd}, 8'hA7);

    // Out of range.
    txn(1'b0, 8'h10, 8'h00, rd, e, lat, bsy);
    check("oor_rd_err", {31'd0, e}, 1);
    check("oor_rd_data", {24'd0, rd}, 8'h00);
    txn(1'b1, 8'hFF, 8'h33, rd, e, lat, bsy);
    check("oor_wr_err", {31'd0, e}, 1);
    cyc();
    check("oor_err_clr", {31'd0, err}, 0);
    for (int i = 0; i < 16; i++) begin
      txn(1'b0, 8'(i), 8'h00, rd, e, lat, bsy);
      check($sformatf("scan%0d", i), {24'd0, rd}, {24'd0, model[i]});
    end

    // Bus changes during WAIT are ignored.
    req = 1'b1; we = 1'b0; addr = 8'd2;
    cyc();
    req = 1'b0; addr = 8'd7; we = 1'b1; wdata = 8'hFF;
    saw = 1'b0;
    for (int i = 0; i < 20; i++) begin
      cyc();
      if (ack) begin
        saw = 1'b1;
        break;
      end
    end
    check("ign_ack", {31'd0, saw}, 1);
    check("ign_data", {24'd0, rdata}, 8'h11);
    txn(1'b0, 8'd7, 8'h00, rd, e, lat, bsy);
    check("ign_no_wr7", {24'd0, rd}, 8'h00);

    // Held req, WAIT_CYCLES=2: acks 4 edges apart.
    req = 1'b1; we = 1'b0; addr = 8'd5;
    cyc();
    t1 = 0; t2 = 0;
    for (int i = 1; i <= 20; i++) begin
      cyc();
      if (ack) begin
        if (t1 == 0) t1 = i;
        else begin
          t2 = i;
          req = 1'b0;
          break;
        end
      end
    end
    check("held_first", t1, 3);
    check("held_second", t2, 7);
    check("held_data", {24'd0, rdata}, 8'hA7);
    repeat (6) cyc();
    check("held_stop", {31'd0, busy}, 0);

    // WAIT_CYCLES=0 instance.
    req0 = 1'b1; we = 1'b0; addr = 8'd0;
    cyc();
    cyc();
    check("w0_ack1", {31'd0, ack0}, 1);
    check("w0_busy1", {31'd0, busy0}, 1);
    check("w0_err1", {31'd0, err0}, 0);
    cyc();
    check("w0_gap", {31'd0, ack0}, 0);
    cyc();
    check("w0_ack2", {31'd0, ack0}, 1);
    req0 = 1'b0;
    cyc();
    check("w0_no_ack3", {31'd0, ack0}, 0);
    cyc();
    check("w0_idle", {31'd0, busy0}, 0);
    req0 = 1'b1; we = 1'b1; addr = 8'd4; wdata = 8'h3C;
    cyc();
    req0 = 1'b0;
    cyc();
    check("w0_wr_ack", {31'd0, ack0}, 1);
    req0 = 1'b1; we = 1'b0;
    cyc();
    req0 = 1'b0;
    cyc();
    check("w0_rd_ack", {31'd0, ack0}, 1);
    check("w0_rd_data", {24'd0, rdata0}, 8'h3C);

`ifdef MEM_RESPONDER_PARITY_EN
    txn(1'b1, 8'd1, 8'h0F, rd, e, lat, bsy);
    u_dut.u_array.mem[1] = u_dut.u_array.mem[1] ^ 9'h001;
    txn(1'b0, 8'd1, 8'h00, rd, e, lat, bsy);
    check("par_lat", lat, 3);
    check("par_err", {31'd0, e}, 1);
    check("par_data", {24'd0, rd}, 8'h0E);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
